board_tile_renderer: RTL and testbench

//  Downstream of the game-board FSM: on a one-cycle start pulse, sweeps all 16x16 board cells held in

---
 rtl/board_tile_renderer_pkg.sv | 29 ++
 rtl/tile_pixel_counter.sv | 39 +++
 rtl/board_tile_renderer.sv | 120 ++++++++++++
 tb/tb_board_tile_renderer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/board_tile_renderer_pkg.sv
// rtl/board_tile_renderer_pkg.sv - shared board geometry, colour constants and renderer state encoding
package board_tile_renderer_pkg;
   localparam int BOARD_DIM = 16;
   localparam int COORD_W   = 4;
   localparam int ADDR_W    = 9;
   localparam int COLOUR_W  = 3;
   localparam int X_W       = 10;
   localparam int Y_W       = 9;

   localparam logic [COLOUR_W-1:0] COLOUR_RED    = 3'b100;
   localparam logic [COLOUR_W-1:0] COLOUR_BLUE   = 3'b001;
   localparam logic [COLOUR_W-1:0] COLOUR_YELLOW = 3'b110;
   localparam logic [COLOUR_W-1:0] COLOUR_BLACK  = 3'b000;
   localparam logic [COLOUR_W-1:0] COLOUR_WHITE  = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_DRAW,
      S_FINISH
   } state_t;

   // An empty cell is stored as black; it is shown in the background colour instead.
   function automatic logic [COLOUR_W-1:0] substitute_bg(input logic [COLOUR_W-1:0] raw,
                                                         input logic [COLOUR_W-1:0] bg);
      return (raw == COLOUR_BLACK) ? bg : raw;
   endfunction
endpackage

// File: rtl/tile_pixel_counter.sv
// rtl/tile_pixel_counter.sv - CELL_W x CELL_W raster counter (px fastest) with last-pixel flag
module tile_pixel_counter #(
   parameter int CELL_W = 28,
   parameter int PW     = (CELL_W > 1) ? $clog2(CELL_W) : 1
) (
   input  logic          i_clock,
   input  logic          i_reset,
   input  logic          i_enable,
   input  logic          i_clear,
   output logic [PW-1:0] o_px,
   output logic [PW-1:0] o_py,
   output logic          o_last
);
   localparam logic [PW-1:0] MAX = PW'(CELL_W - 1);

   logic [PW-1:0] r_px;
   logic [PW-1:0] r_py;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_px <= '0;
         r_py <= '0;
      end else if (i_clear) begin
         r_px <= '0;
         r_py <= '0;
      end else if (i_enable) begin
         if (r_px == MAX) begin
            r_px <= '0;
            r_py <= (r_py == MAX) ? '0 : r_py + 1'b1;
         end else begin
            r_px <= r_px + 1'b1;
         end
      end
   end

   assign o_px   = r_px;
   assign o_py   = r_py;
   assign o_last = (r_px == MAX) && (r_py == MAX);
endmodule

// File: rtl/board_tile_renderer.sv
// rtl/board_tile_renderer.sv - sweeps the 16x16 board BRAM and plots one tile per cell
// Optional build macro GRID_LINES_EN: draws the first row and column of every tile black.
module board_tile_renderer
   import board_tile_renderer_pkg::*;
#(
   parameter int             CELL_W    = 28,
   parameter logic [X_W-1:0] X_ORIGIN  = 10'd96,
   parameter logic [Y_W-1:0] Y_ORIGIN  = 9'd16,
   parameter logic [2:0]     BG_COLOUR = COLOUR_WHITE
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_start,
   output logic [ADDR_W-1:0]   o_rd_address,
   output logic                o_rd_enable,
   input  logic [COLOUR_W-1:0] i_rd_data,
   output logic [X_W-1:0]      o_x_out,
   output logic [Y_W-1:0]      o_y_out,
   output logic [COLOUR_W-1:0] o_colour_out,
   output logic                o_plot,
   output logic                o_busy,
   output logic                o_done
);
   localparam int PW = (CELL_W > 1) ? $clog2(CELL_W) : 1;
   localparam logic [COORD_W-1:0] CELL_MAX = COORD_W'(BOARD_DIM - 1);

   state_t               r_state;
   state_t               w_next;
   logic [COORD_W-1:0]   r_cell_x;
   logic [COORD_W-1:0]   r_cell_y;
   logic [COLOUR_W-1:0]  r_tile_colour;
   logic [PW-1:0]        w_px;
   logic [PW-1:0]        w_py;
   logic                 w_last;
   logic                 w_draw;
   logic                 w_last_cell;
   logic [COLOUR_W-1:0]  w_pix_colour;

   assign w_draw      = (r_state == S_DRAW);
   assign w_last_cell = (r_cell_x == CELL_MAX) && (r_cell_y == CELL_MAX);

   tile_pixel_counter #(.CELL_W(CELL_W), .PW(PW)) u_pixel_counter (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_enable (w_draw),
      .i_clear  (!w_draw),
      .o_px     (w_px),
      .o_py     (w_py),
      .o_last   (w_last)
   );

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (i_start) w_next = S_FETCH;
         S_FETCH:  w_next = S_WAIT;
         S_WAIT:   w_next = S_DRAW;
         S_DRAW:   if (w_last) w_next = w_last_cell ? S_FINISH : S_FETCH;
         S_FINISH: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Cell walk advances on the last pixel of each tile; colour is captured while BRAM q is valid.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_cell_x      <= '0;
         r_cell_y      <= '0;
         r_tile_colour <= '0;
      end else begin
         if (r_state == S_IDLE && i_start) begin
            r_cell_x <= '0;
            r_cell_y <= '0;
         end else if (w_draw && w_last) begin
            r_cell_x <= r_cell_x + 1'b1;
            if (r_cell_x == CELL_MAX) r_cell_y <= r_cell_y + 1'b1;
         end
         if (r_state == S_WAIT) r_tile_colour <= substitute_bg(i_rd_data, BG_COLOUR);
      end
   end

`ifdef GRID_LINES_EN
   assign w_pix_colour = (w_px == '0 || w_py == '0) ? COLOUR_BLACK : r_tile_colour;
`else
   assign w_pix_colour = r_tile_colour;
`endif

   always_comb begin
      o_rd_address = '0;
      o_rd_enable  = 1'b0;
      o_x_out      = '0;
      o_y_out      = '0;
      o_colour_out = '0;
      o_plot       = 1'b0;
      o_busy       = 1'b0;
      o_done       = 1'b0;
      case (r_state)
         S_FETCH: begin
            o_rd_enable  = 1'b1;
            o_rd_address = {1'b0, r_cell_y, r_cell_x};
            o_busy       = 1'b1;
         end
         S_WAIT: o_busy = 1'b1;
         S_DRAW: begin
            o_busy       = 1'b1;
            o_plot       = 1'b1;
            o_x_out      = X_ORIGIN + X_W'(r_cell_x) * X_W'(CELL_W) + X_W'(w_px);
            o_y_out      = Y_ORIGIN + Y_W'(r_cell_y) * Y_W'(CELL_W) + Y_W'(w_py);
            o_colour_out = w_pix_colour;
         end
         S_FINISH: o_done = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: tb/tb_board_tile_renderer.sv
// tb/tb_board_tile_renderer.sv - randomized self-checking bench with a raster reference model
module tb_board_tile_renderer;
   localparam int CW    = 4;
   localparam int TILE  = CW * CW + 2;
   localparam int SWEEP = 256 * TILE;

   typedef struct packed {
      logic [9:0] x;
      logic [8:0] y;
      logic [2:0] c;
   } pix_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [8:0] rd_address;
   logic       rd_enable;
   logic [2:0] rd_data = 3'b000;
   logic [9:0] x_out;
   logic [8:0] y_out;
   logic [2:0] colour_out;
   logic       plot;
   logic       busy;
   logic       done;

   logic [2:0] mem [256];
   pix_t       exp_q [$];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (rd_enable) rd_data <= mem[rd_address[7:0]];

   board_tile_renderer #(.CELL_W(CW)) dut (
      .i_clock      (clk),
      .i_reset      (rst),
      .i_start      (start),
      .o_rd_address (rd_address),
      .o_rd_enable  (rd_enable),
      .i_rd_data    (rd_data),
      .o_x_out      (x_out),
      .o_y_out      (y_out),
      .o_colour_out (colour_out),
      .o_plot       (plot),
      .o_busy       (busy),
      .o_done       (done)
   );

   function automatic void build_model();
      pix_t p;
      int   c;
      exp_q.delete();
      for (int cy = 0; cy < 16; cy++)
         for (int cx = 0; cx < 16; cx++)
            for (int py = 0; py < CW; py++)
               for (int px = 0; px < CW; px++) begin
                  c = int'(mem[cy * 16 + cx]);
                  if (c == 0) c = 7;
`ifdef GRID_LINES_EN
                  if (px == 0 || py == 0) c = 0;
`endif
                  p.x = 10'(96 + cx * CW + px);
                  p.y = 9'(16 + cy * CW + py);
                  p.c = 3'(c);
                  exp_q.push_back(p);
               end
   endfunction

   task automatic run_sweep(input string tag, input int repulse_at, input logic [8:0] watch_addr,
                            output pix_t last_pix);
      int   cyc, idx, done_cnt, done_cyc, busy_bad, last_cyc;
      bit   addr_seen;
      pix_t got;
      build_model();
      idx = 0; done_cnt = 0; done_cyc = -1; busy_bad = 0; last_cyc = -1; addr_seen = 0;
      last_pix = '0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 1;
      while (cyc <= SWEEP + 4) begin
         if (plot === 1'b1) begin
            got = {x_out, y_out, colour_out};
            checks++;
            if (idx >= exp_q.size()) begin
               errors++;
               $display("FAIL %s extra_plot cyc=%0d got x=%0d y=%0d", tag, cyc, x_out, y_out);
            end else if (got !== exp_q[idx]) begin
               errors++;
               $display("FAIL %s pixel[%0d] got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d", tag, idx,
                        got.x, got.y, got.c, exp_q[idx].x, exp_q[idx].y, exp_q[idx].c);
            end
            idx++;
            last_cyc = cyc;
            last_pix = got;
         end
         if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
         if (cyc <= SWEEP && busy !== 1'b1) busy_bad++;
         if (rd_enable === 1'b1 && rd_address === watch_addr) addr_seen = 1;
         start = (cyc == repulse_at);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      checks++;
      if (idx != 256 * CW * CW) begin errors++; $display("FAIL %s plot_count got=%0d want=%0d", tag, idx, 256 * CW * CW); end
      checks++;
      if (done_cnt != 1) begin errors++; $display("FAIL %s done_count got=%0d want=1", tag, done_cnt); end
      checks++;
      if (done_cyc != SWEEP + 1) begin errors++; $display("FAIL %s done_cycle got=%0d want=%0d", tag, done_cyc, SWEEP + 1); end
      checks++;
      if (done_cyc != last_cyc + 1) begin errors++; $display("FAIL %s done_after_last got=%0d want=%0d", tag, done_cyc, last_cyc + 1); end
      checks++;
      if (busy_bad != 0) begin errors++; $display("FAIL %s busy_low_cycles got=%0d want=0", tag, busy_bad); end
      checks++;
      if (!addr_seen) begin errors++; $display("FAIL %s rd_address got=unseen want=%h", tag, watch_addr); end
      checks++;
      if (busy !== 1'b0 || plot !== 1'b0) begin errors++; $display("FAIL %s idle_after got busy=%b plot=%b want 0 0", tag, busy, plot); end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({plot, busy, done, rd_enable, x_out, y_out, colour_out, rd_address} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got plot=%b busy=%b done=%b x=%0d want all 0", plot, busy, done, x_out);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({plot, busy, done, rd_enable} !== 4'b0) begin
         errors++;
         $display("FAIL idle_outputs got plot=%b busy=%b done=%b rd_en=%b want 0", plot, busy, done, rd_enable);
      end
   endtask

   task automatic test_all_empty();
      pix_t lp;
      foreach (mem[i]) mem[i] = 3'b000;
      run_sweep("all_empty", 0, 9'h000, lp);
   endtask

   task automatic test_random_cells();
      pix_t lp;
      pix_t want;
      foreach (mem[i]) mem[i] = 3'($urandom_range(0, 7));
      mem[7 * 16 + 5] = 3'b100;
      mem[255]        = 3'b110;
      run_sweep("random", 0, 9'h075, lp);
      want = {10'(96 + 16 * CW - 1), 9'(16 + 16 * CW - 1), 3'b110};
      checks++;
      if (lp !== want) begin
         errors++;
         $display("FAIL last_pixel got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d", lp.x, lp.y, lp.c, want.x, want.y, want.c);
      end
   endtask

   task automatic test_restart_ignored();
      pix_t lp;
      foreach (mem[i]) mem[i] = 3'($urandom);
      run_sweep("restart_ignored", 100, 9'h0ff, lp);
   endtask

   task automatic test_reset_mid_draw();
      int target;
      pix_t lp;
      target = 1 + (2 * 16 + 3) * TILE + 2 + 5;
      foreach (mem[i]) mem[i] = 3'($urandom);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int cyc = 1; cyc < target; cyc++) @(negedge clk);
      checks++;
      if (plot !== 1'b1 || x_out !== 10'(96 + 3 * CW + 5 % CW) || y_out !== 9'(16 + 2 * CW + 5 / CW)) begin
         errors++;
         $display("FAIL mid_draw_position got plot=%b x=%0d y=%0d want 1 %0d %0d", plot, x_out, y_out,
                  96 + 3 * CW + 5 % CW, 16 + 2 * CW + 5 / CW);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({plot, busy, done, rd_enable, x_out, y_out} !== '0) begin
         errors++;
         $display("FAIL reset_mid_draw got plot=%b busy=%b done=%b x=%0d want all 0", plot, busy, done, x_out);
      end
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b want=0", busy); end
      run_sweep("after_reset", 0, 9'h000, lp);
   endtask

   task automatic test_grid_cell();
      pix_t lp;
      foreach (mem[i]) mem[i] = 3'($urandom);
      mem[0] = 3'b001;
      run_sweep("grid_cell", 0, 9'h000, lp);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      foreach (mem[i]) mem[i] = 3'b000;
      test_reset();
      test_all_empty();
      test_random_cells();
      test_restart_ignored();
      test_reset_mid_draw();
      test_grid_cell();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
